// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
//
// Single-clock FIFO with registered read data and occupancy-based status.
// Storage is 2**ADDRESS_WIDTH words. Read and write pointers are plain binary
// counters that wrap naturally. Occupancy is tracked in a separate counter,
// o_level. Every status flag is decoded from that registered level, so no
// input has a combinational path to any output.
//
// Optional feature (macro PARAM_SYNC_FIFO_ERR_FLAGS_EN):
//   adds sticky o_overflow / o_underflow error outputs.
//
// Ports:
//   i_clk           clock
//   i_rst           synchronous active-high reset
//   i_wr_en         write request (ignored while full)
//   i_wr_data       write word
//   i_rd_en         read request (ignored while empty)
//   o_rd_data       read word, loaded on the edge that accepts a read
//   o_rd_valid      o_rd_data holds a freshly popped word this cycle
//   o_full          level == DEPTH
//   o_almost_full   level >= AFULL_LEVEL
//   o_half_full     level >= DEPTH/2
//   o_empty         level == 0
//   o_almost_empty  level <= AEMPTY_LEVEL
//   o_level         current occupancy, 0..DEPTH
//   o_overflow      (macro only) sticky: a write was rejected because full
//   o_underflow     (macro only) sticky: a read was rejected because empty
// ---------------------------------------------------------------------------
module param_sync_fifo #(
  parameter int DATA_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int AFULL_LEVEL   = 12,
  parameter int AEMPTY_LEVEL  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [DATA_SIZE-1:0]     i_wr_data,
  input  logic                     i_rd_en,
  output logic [DATA_SIZE-1:0]     o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_full,
  output logic                     o_almost_full,
  output logic                     o_half_full,
  output logic                     o_empty,
  output logic                     o_almost_empty,
  output logic [ADDRESS_WIDTH:0]   o_level
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                     o_overflow,
  output logic                     o_underflow
`endif
);

  localparam int DEPTH   = 2 ** ADDRESS_WIDTH;
  localparam int LEVEL_W = ADDRESS_WIDTH + 1;

  localparam logic [LEVEL_W-1:0]       LVL_ZERO   = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W-1:0]       LVL_ONE    = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0]       LVL_FULL   = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0]       LVL_HALF   = LEVEL_W'(DEPTH / 2);
  localparam logic [LEVEL_W-1:0]       LVL_AFULL  = LEVEL_W'(AFULL_LEVEL);
  localparam logic [LEVEL_W-1:0]       LVL_AEMPTY = LEVEL_W'(AEMPTY_LEVEL);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ZERO   = {ADDRESS_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE    = ADDRESS_WIDTH'(1);
  localparam logic [DATA_SIZE-1:0]     DATA_ZERO  = {DATA_SIZE{1'b0}};

  // Storage array. It is deliberately not reset: after a reset the level is
  // zero, so any stale words left in the array can never be read.
  logic [DATA_SIZE-1:0]     mem_q [DEPTH];

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0]       level_q, level_d;
  logic [DATA_SIZE-1:0]     rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;

  logic                     full_s;
  logic                     empty_s;
  logic                     wr_accept_s;
  logic                     rd_accept_s;

  assign full_s  = (level_q == LVL_FULL);
  assign empty_s = (level_q == LVL_ZERO);

  // Accept decisions, pointer/level/read-data next state.
  always_comb begin
    wr_accept_s = i_wr_en & ~full_s;
    rd_accept_s = i_rd_en & ~empty_s;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_accept_s;
    level_d     = level_q;

    if (wr_accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // When no read is accepted, the read data holds its last popped word.
    if (rd_accept_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      rd_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
    end

    // Full and empty gating above already resolves the simultaneous
    // read+write corner cases; only the net change matters here.
    case ({wr_accept_s, rd_accept_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      level_q    <= LVL_ZERO;
      rd_data_q  <= DATA_ZERO;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage write port. Reset blocks writes because the pointers and level
  // restart from zero on that edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_accept_s) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags for requests that were rejected by full or empty.
  always_comb begin
    overflow_d  = overflow_q | (i_wr_en & full_s);
    underflow_d = underflow_q | (i_rd_en & empty_s);
  end

  // Error flag registers; only reset clears them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`endif

  assign o_rd_data      = rd_data_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_level        = level_q;
  assign o_full         = full_s;
  assign o_empty        = empty_s;
  assign o_almost_full  = (level_q >= LVL_AFULL);
  assign o_half_full    = (level_q >= LVL_HALF);
  assign o_almost_empty = (level_q <= LVL_AEMPTY);

endmodule

// File: tb/tb_param_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_param_sync_fifo
//
// Self-checking bench for param_sync_fifo with default parameters.
// A queue holds the words expected out of the FIFO. Words are pushed when
// the bench drives an accepted write, and popped when it drives an accepted
// read. A small occupancy model supplies the expected status flags.
// ---------------------------------------------------------------------------
module tb_param_sync_fifo;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [15:0] i_wr_data = 16'h0000;
  logic        i_rd_en = 1'b0;
  logic [15:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_full, o_almost_full, o_half_full, o_empty, o_almost_empty;
  logic [4:0]  o_level;
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  logic        o_overflow, o_underflow;
`endif

  param_sync_fifo dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_wr_en        (i_wr_en),
    .i_wr_data      (i_wr_data),
    .i_rd_en        (i_rd_en),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_full         (o_full),
    .o_almost_full  (o_almost_full),
    .o_half_full    (o_half_full),
    .o_empty        (o_empty),
    .o_almost_empty (o_almost_empty),
    .o_level        (o_level)
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    ,
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Model state.
  logic [15:0] sb[$];
  int          m_level = 0;
  logic [15:0] m_last  = 16'h0000;
  logic        m_ovf   = 1'b0;
  logic        m_udf   = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic        ev;
  logic [15:0] ed;

  logic [26:0] obs;
  assign obs = {o_rd_valid, o_rd_data, o_full, o_almost_full, o_half_full,
                o_empty, o_almost_empty, o_level};

  // Expected {valid, data, full, afull, half, empty, aempty, level}.
  function automatic logic [26:0] exp_vec(input logic v, input logic [15:0] d,
                                          input int lvl);
    return {v, d, (lvl == 16), (lvl >= 12), (lvl >= 8), (lvl == 0),
            (lvl <= 4), 5'(lvl)};
  endfunction

  // Drive one cycle of requests, update the model, and return the expected
  // read-valid and read-data for the cycle after the edge.
  task automatic drive(input logic wr, input logic [15:0] d, input logic rd,
                       output logic exp_v, output logic [15:0] exp_d);
    logic wacc, racc;
    wacc = wr && (m_level < 16);
    racc = rd && (m_level > 0);
    if (wr && !wacc) m_ovf = 1'b1;
    if (rd && !racc) m_udf = 1'b1;
    if (racc) m_last = sb.pop_front();
    if (wacc) sb.push_back(d);
    m_level = m_level + (wacc ? 1 : 0) - (racc ? 1 : 0);
    exp_v = racc;
    exp_d = m_last;
    i_wr_en = wr; i_wr_data = d; i_rd_en = rd;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0; i_rd_en = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    sb.delete(); m_level = 0; m_last = 16'h0000; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic test_reset();
    // Requests asserted during reset must be ignored.
    i_wr_en = 1'b1; i_rd_en = 1'b1; i_wr_data = 16'hDEAD;
    do_reset();
    n_vec++;
    if (obs !== exp_vec(1'b0, 16'h0000, 0)) begin
      n_err++; $display("FAIL reset_state: got %h expected %h", obs, exp_vec(1'b0, 16'h0000, 0));
    end
    drive(1'b0, 16'h0000, 1'b0, ev, ed);
    n_vec++;
    if (obs !== exp_vec(1'b0, 16'h0000, 0)) begin
      n_err++; $display("FAIL reset_idle: got %h expected %h", obs, exp_vec(1'b0, 16'h0000, 0));
    end
  endtask

  task automatic test_fill(input logic [15:0] base);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, base + 16'(i), 1'b0, ev, ed);
      n_vec++;
      if (obs !== exp_vec(ev, ed, m_level)) begin
        n_err++; $display("FAIL fill[%0d]: got %h expected %h", i, obs, exp_vec(ev, ed, m_level));
      end
    end
    n_vec++;
    if (o_full !== 1'b1 || o_level !== 5'd16) begin
      n_err++; $display("FAIL fill_full: got full=%b level=%0d expected full=1 level=16", o_full, o_level);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 16'h0000, 1'b1, ev, ed);
      n_vec++;
      if (obs !== exp_vec(ev, ed, m_level) || o_rd_data !== 16'(i)) begin
        n_err++; $display("FAIL drain[%0d]: got %h expected %h (data %h)", i, obs, exp_vec(ev, ed, m_level), 16'(i));
      end
    end
    // Idle cycle: valid drops, data holds.
    drive(1'b0, 16'h0000, 1'b0, ev, ed);
    n_vec++;
    if (obs !== exp_vec(1'b0, 16'h000F, 0)) begin
      n_err++; $display("FAIL drain_hold: got %h expected %h", obs, exp_vec(1'b0, 16'h000F, 0));
    end
  endtask

  task automatic test_full_rw();
    logic saw_beef;
    saw_beef = 1'b0;
    test_fill(16'h0100);
    drive(1'b1, 16'hBEEF, 1'b1, ev, ed);
    n_vec++;
    if (obs !== exp_vec(1'b1, 16'h0100, 15)) begin
      n_err++; $display("FAIL full_rw: got %h expected %h", obs, exp_vec(1'b1, 16'h0100, 15));
    end
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 16'h0000, 1'b1, ev, ed);
      if (o_rd_data === 16'hBEEF) saw_beef = 1'b1;
      n_vec++;
      if (obs !== exp_vec(ev, ed, m_level)) begin
        n_err++; $display("FAIL full_rw_drain[%0d]: got %h expected %h", i, obs, exp_vec(ev, ed, m_level));
      end
    end
    n_vec++;
    if (saw_beef !== 1'b0 || o_empty !== 1'b1) begin
      n_err++; $display("FAIL full_rw_drop: got beef_seen=%b empty=%b expected 0 1", saw_beef, o_empty);
    end
  endtask

  task automatic test_empty_rw();
    drive(1'b1, 16'h1234, 1'b1, ev, ed);
    n_vec++;
    if (o_rd_valid !== 1'b0 || o_level !== 5'd1 || obs !== exp_vec(ev, ed, m_level)) begin
      n_err++; $display("FAIL empty_rw: got %h expected %h", obs, exp_vec(ev, ed, m_level));
    end
    drive(1'b0, 16'h0000, 1'b1, ev, ed);
    n_vec++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 16'h1234 || o_level !== 5'd0) begin
      n_err++; $display("FAIL empty_rw_read: got v=%b d=%h l=%0d expected v=1 d=1234 l=0", o_rd_valid, o_rd_data, o_level);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 10; i++) begin
        drive(1'b1, 16'($urandom), 1'b0, ev, ed);
        n_vec++;
        if (obs !== exp_vec(ev, ed, m_level)) begin
          n_err++; $display("FAIL wrap_wr[%0d.%0d]: got %h expected %h", r, i, obs, exp_vec(ev, ed, m_level));
        end
      end
      for (int i = 0; i < 10; i++) begin
        drive(1'b0, 16'h0000, 1'b1, ev, ed);
        n_vec++;
        if (obs !== exp_vec(ev, ed, m_level)) begin
          n_err++; $display("FAIL wrap_rd[%0d.%0d]: got %h expected %h", r, i, obs, exp_vec(ev, ed, m_level));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) drive(1'b1, 16'hA000 + 16'(i), 1'b0, ev, ed);
    drive(1'b0, 16'h0000, 1'b1, ev, ed);
    // Reset with concurrent read and write requests.
    i_wr_en = 1'b1; i_rd_en = 1'b1; i_wr_data = 16'h5555;
    do_reset();
    n_vec++;
    if (obs !== exp_vec(1'b0, 16'h0000, 0)) begin
      n_err++; $display("FAIL reset_mid: got %h expected %h", obs, exp_vec(1'b0, 16'h0000, 0));
    end
    // Old contents must not be readable.
    drive(1'b0, 16'h0000, 1'b1, ev, ed);
    n_vec++;
    if (obs !== exp_vec(1'b0, 16'h0000, 0)) begin
      n_err++; $display("FAIL reset_mid_read: got %h expected %h", obs, exp_vec(1'b0, 16'h0000, 0));
    end
  endtask

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  task automatic test_err_flags();
    do_reset();
    n_vec++;
    if ({o_overflow, o_underflow} !== 2'b00) begin
      n_err++; $display("FAIL err_reset: got %b expected 00", {o_overflow, o_underflow});
    end
    for (int i = 0; i < 16; i++) drive(1'b1, 16'(i), 1'b0, ev, ed);
    drive(1'b1, 16'hFFFF, 1'b0, ev, ed);
    n_vec++;
    if ({o_overflow, o_underflow} !== {m_ovf, m_udf} || o_overflow !== 1'b1) begin
      n_err++; $display("FAIL err_overflow: got %b expected 10", {o_overflow, o_underflow});
    end
    drive(1'b0, 16'h0000, 1'b0, ev, ed);
    n_vec++;
    if (o_overflow !== 1'b1) begin
      n_err++; $display("FAIL err_overflow_sticky: got %b expected 1", o_overflow);
    end
    for (int i = 0; i < 16; i++) drive(1'b0, 16'h0000, 1'b1, ev, ed);
    n_vec++;
    if (o_underflow !== 1'b0) begin
      n_err++; $display("FAIL err_no_underflow: got %b expected 0", o_underflow);
    end
    drive(1'b0, 16'h0000, 1'b1, ev, ed);
    n_vec++;
    if ({o_overflow, o_underflow} !== 2'b11) begin
      n_err++; $display("FAIL err_underflow: got %b expected 11", {o_overflow, o_underflow});
    end
    do_reset();
    n_vec++;
    if ({o_overflow, o_underflow} !== 2'b00) begin
      n_err++; $display("FAIL err_cleared: got %b expected 00", {o_overflow, o_underflow});
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge i_clk);
    test_reset();
    test_fill(16'h0000);
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_reset_mid();
`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
    test_err_flags();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
